data_memory_block: RTL and testbench

Block-granular backing store that sits directly downstream of the data cache and answers its line-fill and write-back requests. Each request moves one 128-bit block (four 32-bit words) after a fixed, parameterised access latency, using the cache's level-sensitive `mem_read`/`mem_write` plus `mem_busywait` handshake. It is the behavioural data memory for CPU-level simulation and has no byte or word access path.

---
 rtl/dmem_pkg.sv | 17 +
 rtl/dmem_latency_counter.sv | 30 +++
 rtl/data_memory_block.sv | 132 +++++++++++++
 tb/tb_data_memory_block.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants and helpers for the block-granular data memory.
// FSM encodings are kept as plain constants to match the legacy code.
package dmem_pkg;

    localparam int unsigned BLOCK_W = 128;
    localparam int unsigned WORD_W  = 32;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] BUSY = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

    // Index width for a table of 'depth' entries; never narrower than one bit.
    function automatic int unsigned row_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dmem_latency_counter.sv
// Down-counter that times one memory access.
// It flags the final BUSY cycle (count == 1) and an expired count (count == 0).
module dmem_latency_counter #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_enable,
    output logic             o_last,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_enable && !o_zero) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_last = (r_count == WIDTH'(1));
    assign o_zero = (r_count == '0);

endmodule

// File: rtl/data_memory_block.sv
// Block-wide backing store behind the data cache: one 128-bit line per request,
// answered after LATENCY cycles using the level-sensitive busywait handshake.
module data_memory_block
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_BLOCKS = 64,
    parameter int unsigned LATENCY      = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [31:0]        mem_address,
    input  logic [BLOCK_W-1:0] mem_writedata,
    output logic [BLOCK_W-1:0] mem_readdata,
    output logic               mem_busywait
);

    localparam int unsigned ROW_W = row_width(DEPTH_BLOCKS);
    localparam int unsigned CNT_W = row_width(LATENCY);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);

    logic [1:0]         r_state;
    logic               r_is_write;
    logic [ROW_W-1:0]   r_row;
    logic [BLOCK_W-1:0] r_wdata;
    logic [BLOCK_W-1:0] r_readdata;
    logic [BLOCK_W-1:0] r_mem [DEPTH_BLOCKS];

    logic               w_req;
    logic [ROW_W-1:0]   w_row_in;
    logic               w_unused_addr;
    logic [1:0]         w_next_state;
    logic               w_load;
    logic               w_last;
    logic               w_zero;
    logic               w_commit;
    logic               w_commit_write;
    logic [ROW_W-1:0]   w_commit_row;
    logic [BLOCK_W-1:0] w_commit_data;

    assign w_req         = mem_read | mem_write;
    assign w_row_in      = mem_address[ROW_W-1:0];
    assign w_unused_addr = ^mem_address[31:ROW_W];

    dmem_latency_counter #(
        .WIDTH (CNT_W)
    ) u_counter (
        .clock        (clock),
        .reset        (reset),
        .i_load       (w_load),
        .i_load_value (LOAD_VAL),
        .i_enable     (r_state == BUSY),
        .o_last       (w_last),
        .o_zero       (w_zero)
    );

    // With LATENCY == 1 the commit happens on the accepting edge, so it uses
    // the live request inputs instead of the captured copies.
    always_comb begin
        w_next_state   = r_state;
        w_load         = 1'b0;
        w_commit       = 1'b0;
        w_commit_write = r_is_write;
        w_commit_row   = r_row;
        w_commit_data  = r_wdata;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_load = 1'b1;
                    if (LATENCY == 1) begin
                        w_next_state   = DONE;
                        w_commit       = 1'b1;
                        w_commit_write = mem_write;
                        w_commit_row   = w_row_in;
                        w_commit_data  = mem_writedata;
                    end else begin
                        w_next_state = BUSY;
                    end
                end
            end
            BUSY: begin
                if (!w_req) begin
                    w_next_state = IDLE;
                end else if (w_last || w_zero) begin
                    w_next_state = DONE;
                    w_commit     = 1'b1;
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_is_write <= 1'b0;
            r_row      <= '0;
            r_wdata    <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == IDLE && w_req) begin
                r_is_write <= mem_write;
                r_row      <= w_row_in;
                r_wdata    <= mem_writedata;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH_BLOCKS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_commit && w_commit_write) begin
            r_mem[w_commit_row] <= w_commit_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_readdata <= '0;
        end else if (w_commit && !w_commit_write) begin
            r_readdata <= r_mem[w_commit_row];
        end
    end

    assign mem_readdata = r_readdata;
    assign mem_busywait = reset & (((r_state == IDLE) & w_req) | (r_state == BUSY));

endmodule

// File: tb/tb_data_memory_block.sv
// Randomized and directed checks of data_memory_block at LATENCY 4 and 1
// against a per-block array model of the memory contents.
module tb_data_memory_block;

    localparam int DEPTH = 64;

    logic         clk = 1'b0;
    logic         rst_n [2];
    logic         rd    [2];
    logic         wr    [2];
    logic [31:0]  addr  [2];
    logic [127:0] wdata [2];
    logic [127:0] rdata [2];
    logic         busy  [2];

    logic [127:0] mdl_mem [2][DEPTH];
    logic [127:0] mdl_rd  [2];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    data_memory_block #(.DEPTH_BLOCKS(64), .LATENCY(4)) dut4 (
        .clock(clk), .reset(rst_n[0]), .mem_read(rd[0]), .mem_write(wr[0]),
        .mem_address(addr[0]), .mem_writedata(wdata[0]),
        .mem_readdata(rdata[0]), .mem_busywait(busy[0])
    );

    data_memory_block #(.DEPTH_BLOCKS(64), .LATENCY(1)) dut1 (
        .clock(clk), .reset(rst_n[1]), .mem_read(rd[1]), .mem_write(wr[1]),
        .mem_address(addr[1]), .mem_writedata(wdata[1]),
        .mem_readdata(rdata[1]), .mem_busywait(busy[1])
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic idle_inputs(input int d);
        rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
    endtask

    task automatic model_reset(input int d);
        for (int i = 0; i < DEPTH; i++) mdl_mem[d][i] = '0;
        mdl_rd[d] = '0;
    endtask

    // Full cache-style transaction; entered between edges, leaves between edges.
    task automatic txn(input int d, input logic r, input logic w,
                       input logic [31:0] a, input logic [127:0] data, input string tag);
        int   L = lat_of(d);
        logic exp_busy;
        rd[d] = r; wr[d] = w; addr[d] = a; wdata[d] = data;
        for (int c = 0; c <= L; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            exp_busy = (c < L);
            n_cmp++;
            if (busy[d] !== exp_busy) begin
                n_fail++;
                $display("FAIL %s busy cyc%0d: got %b exp %b", tag, c, busy[d], exp_busy);
            end
        end
        if (w) mdl_mem[d][a[5:0]] = data;
        else   mdl_rd[d] = mdl_mem[d][a[5:0]];
        n_cmp++;
        if (rdata[d] !== mdl_rd[d]) begin
            n_fail++;
            $display("FAIL %s rdata: got %h exp %h", tag, rdata[d], mdl_rd[d]);
        end
        @(negedge clk);
        idle_inputs(d);
        #1;
        n_cmp++;
        if (busy[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy after release: got %b exp 0", tag, busy[d]);
        end
    endtask

    task automatic test_reset();
        idle_inputs(0); idle_inputs(1);
        rst_n[0] = 1'b0; rst_n[1] = 1'b0;
        rd[0] = 1'b1;
        @(negedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (busy[d] !== 1'b0) begin
                n_fail++; $display("FAIL reset busy d%0d: got %b exp 0", d, busy[d]);
            end
            n_cmp++;
            if (rdata[d] !== 128'h0) begin
                n_fail++; $display("FAIL reset rdata d%0d: got %h exp 0", d, rdata[d]);
            end
        end
        rd[0] = 1'b0;
        model_reset(0); model_reset(1);
        @(negedge clk);
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        @(negedge clk);
        txn(0, 1'b1, 1'b0, 32'd5, '0, "read_blk5_after_reset");
    endtask

    task automatic test_write_read();
        logic [127:0] v = 128'hDEADBEEF_0BADF00D_12345678_CAFEBABE;
        txn(0, 1'b0, 1'b1, 32'd3, v, "write_blk3");
        txn(0, 1'b1, 1'b0, 32'd3, '0, "read_blk3");
        n_cmp++;
        if (rdata[0] !== v) begin
            n_fail++; $display("FAIL read_blk3 literal: got %h exp %h", rdata[0], v);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] v = rand128();
        logic [127:0] old_rd = mdl_rd[0];
        logic         exp_busy;
        rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = 32'd2; wdata[0] = v;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 4) begin wr[0] = 1'b0; rd[0] = 1'b1; wdata[0] = '0; end
            #1;
            exp_busy = (c != 4) && (c != 9);
            n_cmp++;
            if (busy[0] !== exp_busy) begin
                n_fail++; $display("FAIL b2b busy cyc%0d: got %b exp %b", c, busy[0], exp_busy);
            end
            if (c == 4 || c == 8) begin
                n_cmp++;
                if (rdata[0] !== old_rd) begin
                    n_fail++; $display("FAIL b2b early rdata cyc%0d: got %h exp %h", c, rdata[0], old_rd);
                end
            end
        end
        mdl_mem[0][2] = v; mdl_rd[0] = v;
        n_cmp++;
        if (rdata[0] !== v) begin
            n_fail++; $display("FAIL b2b read DONE rdata: got %h exp %h", rdata[0], v);
        end
        @(negedge clk);
        idle_inputs(0);
    endtask

    task automatic test_alias();
        txn(0, 1'b0, 1'b1, 32'd71, rand128(), "alias_write71");
        txn(0, 1'b1, 1'b0, 32'd7, '0, "alias_read7");
    endtask

    task automatic test_drop();
        txn(0, 1'b0, 1'b1, 32'd11, rand128(), "drop_prefill");
        wr[0] = 1'b1; addr[0] = 32'd11; wdata[0] = rand128();
        @(negedge clk); @(negedge clk);
        idle_inputs(0);
        #1;
        n_cmp++;
        if (busy[0] !== 1'b1) begin
            n_fail++; $display("FAIL drop busy in BUSY: got %b exp 1", busy[0]);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (busy[0] !== 1'b0) begin
            n_fail++; $display("FAIL drop busy after: got %b exp 0", busy[0]);
        end
        txn(0, 1'b1, 1'b0, 32'd11, '0, "drop_readback");
    endtask

    task automatic test_reset_mid();
        txn(0, 1'b0, 1'b1, 32'd9, rand128(), "rstmid_prefill");
        wr[0] = 1'b1; addr[0] = 32'd9; wdata[0] = rand128();
        @(negedge clk); @(negedge clk);
        rst_n[0] = 1'b0;
        #1;
        n_cmp++;
        if (busy[0] !== 1'b0) begin
            n_fail++; $display("FAIL rstmid busy: got %b exp 0", busy[0]);
        end
        model_reset(0);
        @(negedge clk);
        idle_inputs(0);
        n_cmp++;
        if (rdata[0] !== 128'h0) begin
            n_fail++; $display("FAIL rstmid rdata: got %h exp 0", rdata[0]);
        end
        @(negedge clk);
        rst_n[0] = 1'b1;
        @(negedge clk);
        txn(0, 1'b1, 1'b0, 32'd9, '0, "rstmid_read9");
    endtask

    task automatic test_lat1();
        txn(1, 1'b0, 1'b1, 32'd4, rand128(), "lat1_write4");
        txn(1, 1'b1, 1'b0, 32'd4, '0, "lat1_read4");
        txn(1, 1'b1, 1'b1, 32'd4, rand128(), "lat1_both4");
        txn(1, 1'b1, 1'b0, 32'd4, '0, "lat1_readback4");
    endtask

    task automatic test_random();
        int   kind;
        int   d;
        logic [31:0] a;
        for (int i = 0; i < 40; i++) begin
            d    = (i % 4 == 3) ? 1 : 0;
            kind = $urandom_range(0, 2);
            a    = ($urandom & 32'hFFFF_FFC0) | 32'($urandom_range(0, 7));
            txn(d, kind != 1, kind != 0, a, rand128(), "random");
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_alias();
        test_drop();
        test_reset_mid();
        test_lat1();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
